// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extraction, writeback source
// select, register-file write port and retired-instruction counter.
module wb_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd,
  input  logic [1:0]           mem_wb_sel,
  input  logic [31:0]          mem_alu_result,
  input  logic [31:0]          mem_load_data,
  input  logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_pc,
  input  logic [31:0]          mem_imm,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 write_reg,
  output logic [4:0]           target_reg,
  output logic [31:0]          write_rd_data,
  output logic                 wb_valid,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  // Byte/halfword/word extraction from an aligned little-endian word.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  a,
                                               input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0]          wb_val_s;
  logic                 we_s;
  logic                 valid_r;
  logic                 we_r;
  logic [4:0]           rd_r;
  logic [31:0]          data_r;
  logic [INSTRET_W-1:0] instret_r;

  // Select the final writeback value before capture so the write port is a pure register.
  always_comb begin
    wb_val_s = 32'd0;
    we_s     = mem_valid & mem_reg_write & (mem_rd != 5'd0);
    case (mem_wb_sel)
      2'b00:   wb_val_s = mem_alu_result;
      2'b01:   wb_val_s = extract_load(mem_load_data, mem_alu_result[1:0], mem_funct3);
      2'b10:   wb_val_s = mem_pc + 32'd4;
      2'b11:   wb_val_s = mem_imm;
      default: wb_val_s = 32'd0;
    endcase
  end

  // WB register holds already-qualified write-port values: index/data are zero
  // whenever no write happens, so the bypass never forwards a false match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      rd_r    <= 5'd0;
      data_r  <= 32'd0;
    end else if (flush) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      rd_r    <= 5'd0;
      data_r  <= 32'd0;
    end else if (stall) begin
      valid_r <= valid_r;
      we_r    <= we_r;
      rd_r    <= rd_r;
      data_r  <= data_r;
    end else begin
      valid_r <= mem_valid;
      we_r    <= we_s;
      rd_r    <= we_s ? mem_rd : 5'd0;
      data_r  <= we_s ? wb_val_s : 32'd0;
    end
  end

  // Count an instruction when it leaves WB (valid, not held, not killed).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_r <= {INSTRET_W{1'b0}};
    end else if (valid_r && !stall && !flush) begin
      instret_r <= instret_r + INSTRET_ONE;
    end else begin
      instret_r <= instret_r;
    end
  end

  assign write_reg     = we_r;
  assign target_reg    = rd_r;
  assign write_rd_data = data_r;
  assign wb_valid      = valid_r;
  assign instret       = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage against a behavioural writeback model.
`timescale 1ns/1ps
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_reg_write, stall, flush;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc, mem_imm;
  logic [2:0]  mem_funct3;
  logic        write_reg, wb_valid;
  logic [4:0]  target_reg;
  logic [31:0] write_rd_data;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  // Model state: the instruction sitting in WB, unqualified.
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_instret;

  wb_stage #(.INSTRET_W(64)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_funct3(mem_funct3), .mem_pc(mem_pc),
    .mem_imm(mem_imm), .stall(stall), .flush(flush), .write_reg(write_reg),
    .target_reg(target_reg), .write_rd_data(write_rd_data), .wb_valid(wb_valid),
    .instret(instret)
  );

  always #5 clk = ~clk;

  wire [102:0] dut_out = {write_reg, target_reg, write_rd_data, wb_valid, instret};

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [31:0] b, h;
    b = (word >> (8 * a)) & 32'hFF;
    h = (word >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      3'b010:  return word;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [102:0] exp_out();
    logic we;
    we = m_valid && m_rw && (m_rd != 5'd0);
    return {we, we ? m_rd : 5'd0, we ? m_data : 32'd0, m_valid, m_instret};
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic [31:0] v;
    if (!rst) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_instret = 64'd0;
    end else begin
      if (m_valid && !stall && !flush) m_instret = m_instret + 64'd1;
      if (flush) begin
        m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_data = 32'd0;
      end else if (!stall) begin
        case (mem_wb_sel)
          2'b00:   v = mem_alu_result;
          2'b01:   v = m_load(mem_load_data, mem_alu_result[1:0], mem_funct3);
          2'b10:   v = mem_pc + 32'd4;
          default: v = mem_imm;
        endcase
        m_valid = mem_valid;
        m_rw    = mem_valid && mem_reg_write;
        m_rd    = mem_valid ? mem_rd : 5'd0;
        m_data  = mem_valid ? v : 32'd0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic st, input logic fl);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_alu_result = alu; mem_load_data = ld; mem_funct3 = f3;
    mem_pc = pc; mem_imm = imm; stall = st; flush = fl;
  endtask

  task automatic drive_random(input int stall_pct, input int flush_pct);
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), 2'($urandom),
          $urandom, $urandom, 3'($urandom), $urandom, $urandom,
          1'($urandom_range(0, 99) < stall_pct), 1'($urandom_range(0, 99) < flush_pct));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_random(20, 20);
      cycle();
      checks++;
      if (dut_out !== 103'd0) begin
        errors++;
        $display("FAIL reset_hold: got %h expected 0", dut_out);
      end
    end
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    // Load a write, then assert reset mid-cycle.
    drive(1'b1, 1'b1, 5'd3, 2'b00, 32'h0BADF00D, 32'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (write_reg !== 1'b1 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL reset_prewrite: got %h expected %h", dut_out, exp_out());
    end
    #2 rst = 1'b0;
    #1;
    m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_instret = 64'd0;
    checks++;
    if (dut_out !== 103'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", dut_out);
    end
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_alu_write();
    logic [63:0] base;
    base = m_instret;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (write_reg !== 1'b1 || target_reg !== 5'd5 || write_rd_data !== 32'hDEADBEEF ||
        dut_out !== exp_out()) begin
      errors++;
      $display("FAIL alu_write: got %h expected %h", dut_out, exp_out());
    end
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (instret !== base + 64'd1 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL alu_retire: got %h expected %h", dut_out, exp_out());
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [1:0]  as  [6] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [31:0] exps[6] = '{32'hFFFFFF80, 32'h000000A1, 32'hFFFF8070,
                             32'h0000F0A1, 32'h8070F0A1, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'd9, 2'b01, {30'h1000, as[i]}, 32'h8070F0A1, f3s[i],
            32'h0, 32'h0, 1'b0, 1'b0);
      cycle();
      checks++;
      if (write_rd_data !== exps[i] || dut_out !== exp_out()) begin
        errors++;
        $display("FAIL load_%0d: got data %h expected %h (full %h vs %h)",
                 i, write_rd_data, exps[i], dut_out, exp_out());
      end
    end
  endtask

  task automatic test_x0();
    logic [63:0] base;
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h12345678, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    base = instret;
    checks++;
    if (write_reg !== 1'b0 || target_reg !== 5'd0 || write_rd_data !== 32'd0 ||
        wb_valid !== 1'b1 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL x0_write: got %h expected %h", dut_out, exp_out());
    end
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (instret !== base + 64'd1 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL x0_retire: got %h expected %h", dut_out, exp_out());
    end
  endtask

  task automatic test_stall_flush();
    logic [102:0] held;
    drive(1'b1, 1'b1, 5'd7, 2'b11, 32'h0, 32'h0, 3'd0, 32'h0, 32'h55AA1234, 1'b0, 1'b0);
    cycle();
    held = exp_out();
    checks++;
    if (dut_out !== held) begin
      errors++;
      $display("FAIL stall_capture: got %h expected %h", dut_out, held);
    end
    for (int i = 0; i < 3; i++) begin
      drive_random(0, 0);
      stall = 1'b1;
      cycle();
      checks++;
      if (dut_out !== held || dut_out !== exp_out()) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, dut_out, held);
      end
    end
    drive_random(0, 0);
    stall = 1'b1; flush = 1'b1;
    cycle();
    checks++;
    if (wb_valid !== 1'b0 || write_reg !== 1'b0 || instret !== held[63:0] ||
        dut_out !== exp_out()) begin
      errors++;
      $display("FAIL stall_flush: got %h expected %h", dut_out, exp_out());
    end
  endtask

  task automatic test_pc_imm();
    drive(1'b1, 1'b1, 5'd12, 2'b10, 32'h0, 32'h0, 3'd0, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (write_rd_data !== 32'h0 || write_reg !== 1'b1 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL pc4_wrap: got %h expected %h", dut_out, exp_out());
    end
    drive(1'b1, 1'b1, 5'd13, 2'b11, 32'h0, 32'h0, 3'd0, 32'h100, 32'hABCDE000, 1'b0, 1'b0);
    cycle();
    checks++;
    if (write_rd_data !== 32'hABCDE000 || dut_out !== exp_out()) begin
      errors++;
      $display("FAIL imm_write: got %h expected %h", dut_out, exp_out());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random(20, 10);
      cycle();
      checks++;
      if (dut_out !== exp_out()) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", i, dut_out, exp_out());
      end
    end
  endtask

  initial begin
    m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_instret = 64'd0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    test_reset();
    test_alu_write();
    test_load();
    test_x0();
    test_stall_flush();
    test_pc_imm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage pipeline and the writer side of the register file's write port. Captures the MEM-stage result into a MEM/WB pipeline register, performs load-data extraction and sign/zero extension, selects the writeback source, and drives `write_reg` / `target_reg` / `write_rd_data` into the register file. It also maintains the retired-instruction counter.

## Interface

Parameters:
- `INSTRET_W`, default 64: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `mem_valid`, input, 1: the MEM stage holds a real instruction (0 = bubble).
- `mem_reg_write`, input, 1: the instruction writes rd.
- `mem_rd`, input, 5: destination register index.
- `mem_wb_sel`, input, 2: writeback source. 00 = ALU, 01 = load, 10 = PC+4, 11 = immediate (LUI).
- `mem_alu_result`, input, 32: ALU result. For loads, this is the byte address.
- `mem_load_data`, input, 32: raw aligned word from data memory.
- `mem_funct3`, input, 3: load width/sign code.
- `mem_pc`, input, 32: instruction PC.
- `mem_imm`, input, 32: U-type immediate.
- `stall`, input, 1: hold the WB register.
- `flush`, input, 1: load a bubble into the WB register.
- `write_reg`, output, 1: register-file write enable.
- `target_reg`, output, 5: register-file write index.
- `write_rd_data`, output, 32: register-file write data.
- `wb_valid`, output, 1: the WB register holds a real instruction.
- `instret`, output, INSTRET_W: count of retired instructions.

## Operation

- WB register fields: `valid`, `reg_write`, `rd`, `data[31:0]`. The final writeback value is computed before capture, so `write_rd_data` is a pure register output.
- Capture value by `mem_wb_sel`:
  - ALU: `mem_alu_result`.
  - PC+4: `mem_pc + 4`, mod 2^32.
  - Immediate: `mem_imm`.
  - Load: extracted from `mem_load_data` using `a = mem_alu_result[1:0]`, little-endian.
- Load extraction by `mem_funct3`:
  - 000 LB: byte `a`, sign-extended.
  - 100 LBU: byte `a`, zero-extended.
  - 001 LH: halfword selected by `a[1]`, sign-extended. `a[0]` is ignored.
  - 101 LHU: as LH, zero-extended.
  - 010 LW: full word. `a` is ignored.
  - Any other code: data = 0.
- Outputs (combinational from the WB register only):
  - `write_reg = valid & reg_write & (rd != 0)`.
  - `target_reg = write_reg ? rd : 0`.
  - `write_rd_data = write_reg ? data : 0`.
  - Rationale: the register file's read bypass compares `rs` against `target_reg` without qualifying on `write_reg`. Driving 0 prevents false forwarding, because index 0 always reads as zero.
- `wb_valid = valid`.
- Update priority at each rising edge:
  1. `flush`: WB register becomes a bubble (all fields 0). Flush beats stall.
  2. `stall`: WB register holds. Outputs are unchanged, so the register file rewrites the same value each stalled cycle (idempotent).
  3. Otherwise: capture the MEM inputs. If `mem_valid = 0`, capture a bubble.
- `instret` increments by 1 on each edge where `valid = 1`, `stall = 0` and `flush = 0` (the instruction leaves WB). It wraps to 0 at 2^INSTRET_W − 1.
  - Bubbles never count.
  - A flushed WB instruction does not count.
  - x0-destination and non-writing instructions (stores, branches) do count when valid.

## Timing

- Reset (`rst` = 0, asynchronous): WB register cleared immediately, mid-cycle. Also:
  - `write_reg` = 0, `target_reg` = 0, `write_rd_data` = 0.
  - `wb_valid` = 0, `instret` = 0.
  - A pending write is dropped.
  - Deassertion takes effect at the next rising edge.
- Latency: MEM inputs sampled at edge N appear on the write port after edge N. The register file commits at edge N+1.
  - In-cycle bypass: during the cycle between N and N+1, a decode-stage read of the same rd sees the new value.
- No handshake back to MEM. The hazard unit owns `stall`/`flush`, and the block accepts them in any combination on any cycle.

## Test plan

- **Reset:** hold `rst` = 0 with random inputs toggling, then assert `rst` = 0 mid-cycle while `write_reg` = 1 → all outputs go to 0 immediately, with no clock edge needed.
- **ALU write:** `mem_valid` = 1, `reg_write` = 1, rd = 5, sel = ALU, result = 0xDEADBEEF → after one edge, `write_reg` = 1, `target_reg` = 5, `write_rd_data` = 0xDEADBEEF, and `instret` increments on the following unstalled edge.
- **Load extraction:** word = 0x8070F0A1.
  - LB with `a` = 3 → 0xFFFFFF80.
  - LBU with `a` = 0 → 0x000000A1.
  - LH with `a` = 2 → 0xFFFF8070.
  - LHU with `a` = 0 → 0x0000F0A1.
  - LW → 0x8070F0A1.
  - funct3 = 011 → 0.
- **x0 destination:** rd = 0, `reg_write` = 1, data = 0x12345678 → `write_reg` = 0, `target_reg` = 0, `write_rd_data` = 0, but `instret` still increments.
- **Stall/flush:** capture rd = 7, then `stall` for 3 cycles → outputs stay constant and `instret` is unchanged. Then `stall` = 1 and `flush` = 1 together → bubble loaded, `wb_valid` = 0, `instret` unchanged.
- **PC+4 and immediate:** sel = PC+4 with pc = 0xFFFFFFFC → data = 0x00000000. Sel = immediate with imm = 0xABCDE000 → data = 0xABCDE000.
